// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised pipeline register chain with per-stage
// valid bits, optional bubble collapse, flush and occupancy tracking.
module pipe_stage_chain #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 1,
  parameter logic [DATA_W-1:0] BUBBLE   = '0,
  parameter int                COLLAPSE = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         STALL_IN,
  input  logic                         STALL_OUT,
  input  logic                         FLUSH,
  input  logic                         IN_VALID,
  input  logic [DATA_W-1:0]            IN_DATA,
  output logic                         OUT_VALID,
  output logic [DATA_W-1:0]            OUT_DATA,
  output logic                         STALL_REQ,
  output logic [$clog2(DEPTH+1)-1:0]   OCCUPANCY
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  v_d;
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [OW-1:0]     occ_q;
  logic [OW-1:0]     occ_d;
  logic [DEPTH:0]    load;
  logic              acc;
  logic              pop;

  // Load enables ripple from the output side back to stage 0.
  always_comb begin
    load = '0;
    load[DEPTH] = ~STALL_OUT;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (COLLAPSE != 0) begin
        load[i] = ~v_q[i] | load[i+1];
      end else begin
        load[i] = load[DEPTH];
      end
    end
    acc = load[0] & ~STALL_IN & IN_VALID;
    pop = v_q[DEPTH-1] & ~STALL_OUT;
  end

  // Next-state: shift loaded stages, fill stage 0, track occupancy.
  always_comb begin
    v_d   = v_q;
    d_d   = d_q;
    occ_d = occ_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end
    if (load[0]) begin
      v_d[0] = acc;
      d_d[0] = acc ? IN_DATA : BUBBLE;
    end
    if (acc && !pop) begin
      occ_d = occ_q + OW'(1);
    end else if (!acc && pop) begin
      occ_d = occ_q - OW'(1);
    end
    if (FLUSH) begin
      v_d   = '0;
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_d[i] = BUBBLE;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= BUBBLE;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign OUT_VALID = v_q[DEPTH-1];
  assign OUT_DATA  = d_q[DEPTH-1];
  assign STALL_REQ = ~load[0];
  assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: lockstep and collapse instances driven in parallel,
// checked against directed vectors and a slot-array reference model.
module tb_pipe_stage_chain;

  localparam int D = 3;

  logic       CLK = 0;
  logic       RST = 0;
  logic       STALL_IN = 0;
  logic       STALL_OUT = 0;
  logic       FLUSH = 0;
  logic       IN_VALID = 0;
  logic [7:0] IN_DATA = 0;

  logic       ov  [2];
  logic [7:0] od  [2];
  logic       sr  [2];
  logic [1:0] occ [2];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipe_stage_chain #(.DATA_W(8), .DEPTH(D), .BUBBLE(8'h00), .COLLAPSE(0)) u0 (
    .CLK(CLK), .RST(RST), .STALL_IN(STALL_IN), .STALL_OUT(STALL_OUT),
    .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .OUT_VALID(ov[0]), .OUT_DATA(od[0]), .STALL_REQ(sr[0]),
    .OCCUPANCY(occ[0])
  );

  pipe_stage_chain #(.DATA_W(8), .DEPTH(D), .BUBBLE(8'h00), .COLLAPSE(1)) u1 (
    .CLK(CLK), .RST(RST), .STALL_IN(STALL_IN), .STALL_OUT(STALL_OUT),
    .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .OUT_VALID(ov[1]), .OUT_DATA(od[1]), .STALL_REQ(sr[1]),
    .OCCUPANCY(occ[1])
  );

  // Reference model: one slot array per instance, slot D-1 is the output.
  logic       mv [2][D];
  logic [7:0] md [2][D];
  bit         model_ok = 0;
  logic       a_sr [2];

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic m_sr(int k, logic so);
    logic full;
    full = 1'b1;
    for (int i = 0; i < D; i++) full = full & mv[k][i];
    return (k == 0) ? so : (so & full);
  endfunction

  function automatic int m_occ(int k);
    int n;
    n = 0;
    for (int i = 0; i < D; i++) n += int'(mv[k][i]);
    return n;
  endfunction

  // The stall boundary: everything at or below 'top' advances one slot.
  task automatic m_step(int k, logic rst, logic si, logic so, logic fl,
                        logic iv, logic [7:0] id);
    int top;
    if (!rst || fl) begin
      for (int i = 0; i < D; i++) begin
        mv[k][i] = 0;
        md[k][i] = 8'h00;
      end
      return;
    end
    top = -1;
    if (!so) begin
      top = D - 1;
    end else if (k == 1) begin
      for (int i = 0; i < D; i++) if (!mv[k][i]) top = i;
    end
    for (int i = top; i >= 1; i--) begin
      mv[k][i] = mv[k][i-1];
      md[k][i] = md[k][i-1];
    end
    if (top >= 0) begin
      mv[k][0] = !si && iv;
      md[k][0] = (!si && iv) ? id : 8'h00;
    end
  endtask

  task automatic cycle(logic rst, logic si, logic so, logic fl, logic iv,
                       logic [7:0] id);
    @(negedge CLK);
    RST = rst; STALL_IN = si; STALL_OUT = so;
    FLUSH = fl; IN_VALID = iv; IN_DATA = id;
    #1;
    for (int k = 0; k < 2; k++) begin
      a_sr[k] = sr[k];
      if (model_ok) chk("model_stall_req", k, 32'(sr[k]), 32'(m_sr(k, so)));
    end
    @(posedge CLK);
    for (int k = 0; k < 2; k++) m_step(k, rst, si, so, fl, iv, id);
    if (!rst) model_ok = 1;
    #1;
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        chk("model_out_valid", k, 32'(ov[k]), 32'(mv[k][D-1]));
        chk("model_out_data", k, 32'(od[k]), 32'(md[k][D-1]));
        chk("model_occupancy", k, 32'(occ[k]), 32'(m_occ(k)));
      end
    end
  endtask

  typedef struct {
    int         t;
    logic       rst, si, so, fl, iv;
    logic [7:0] id;
    logic       sr, ov;
    logic [7:0] od;
    logic [1:0] oc;
  } vec_t;

  vec_t vq[$];

  task automatic add(int t, logic rst, logic si, logic so, logic fl,
                     logic iv, logic [7:0] id, logic e_sr, logic e_ov,
                     logic [7:0] e_od, logic [1:0] e_oc);
    vec_t v;
    v.t = t; v.rst = rst; v.si = si; v.so = so; v.fl = fl;
    v.iv = iv; v.id = id; v.sr = e_sr; v.ov = e_ov;
    v.od = e_od; v.oc = e_oc;
    vq.push_back(v);
  endtask

  initial begin
    // lockstep: reset with live input
    add(0, 0,0,0,0,1,8'hAA, 0,0,8'h00,0);
    add(0, 0,0,0,0,1,8'hAA, 0,0,8'h00,0);
    // streaming
    add(0, 1,0,0,0,1,8'h01, 0,0,8'h00,1);
    add(0, 1,0,0,0,1,8'h02, 0,0,8'h00,2);
    add(0, 1,0,0,0,1,8'h03, 0,1,8'h01,3);
    add(0, 1,0,0,0,0,8'h00, 0,1,8'h02,2);
    add(0, 1,0,0,0,0,8'h00, 0,1,8'h03,1);
    add(0, 1,0,0,0,0,8'h00, 0,0,8'h00,0);
    // bubble insertion
    add(0, 1,0,0,0,1,8'h11, 0,0,8'h00,1);
    add(0, 1,1,0,0,1,8'hFF, 0,0,8'h00,1);
    add(0, 1,0,0,0,1,8'h22, 0,1,8'h11,2);
    add(0, 1,0,0,0,0,8'h00, 0,0,8'h00,1);
    add(0, 1,0,0,0,0,8'h00, 0,1,8'h22,1);
    add(0, 1,0,0,0,0,8'h00, 0,0,8'h00,0);
    // lockstep hold
    add(0, 1,0,0,0,1,8'h33, 0,0,8'h00,1);
    add(0, 1,0,0,0,0,8'h00, 0,0,8'h00,1);
    add(0, 1,0,0,0,0,8'h00, 0,1,8'h33,1);
    add(0, 1,0,1,0,1,8'h77, 1,1,8'h33,1);
    add(0, 1,0,1,0,1,8'h77, 1,1,8'h33,1);
    add(0, 1,0,0,0,0,8'h00, 0,0,8'h00,0);
    // flush of a full, stalled chain
    add(0, 1,0,0,0,1,8'hA1, 0,0,8'h00,1);
    add(0, 1,0,0,0,1,8'hA2, 0,0,8'h00,2);
    add(0, 1,0,0,0,1,8'hA3, 0,1,8'hA1,3);
    add(0, 1,0,1,1,1,8'hA4, 1,0,8'h00,0);
    add(0, 1,0,0,0,0,8'h00, 0,0,8'h00,0);
    // reset mid-operation, then latency DEPTH
    add(0, 1,0,0,0,1,8'hB1, 0,0,8'h00,1);
    add(0, 1,0,0,0,1,8'hB2, 0,0,8'h00,2);
    add(0, 0,0,1,0,1,8'hB3, 1,0,8'h00,0);
    add(0, 1,0,0,0,1,8'hC1, 0,0,8'h00,1);
    add(0, 1,0,0,0,0,8'h00, 0,0,8'h00,1);
    add(0, 1,0,0,0,0,8'h00, 0,1,8'hC1,1);
    add(0, 1,0,0,0,0,8'h00, 0,0,8'h00,0);
    // collapse: [44,bub,bub] stalled, 55 and 66 fill the gaps
    add(1, 0,0,0,0,0,8'h00, 0,0,8'h00,0);
    add(1, 1,0,0,0,1,8'h44, 0,0,8'h00,1);
    add(1, 1,0,0,0,0,8'h00, 0,0,8'h00,1);
    add(1, 1,0,0,0,0,8'h00, 0,1,8'h44,1);
    add(1, 1,0,1,0,1,8'h55, 0,1,8'h44,2);
    add(1, 1,0,1,0,1,8'h66, 0,1,8'h44,3);
    add(1, 1,0,1,0,1,8'h77, 1,1,8'h44,3);
    add(1, 1,0,0,0,0,8'h00, 0,1,8'h55,2);
    add(1, 1,0,0,0,0,8'h00, 0,1,8'h66,1);
    add(1, 1,0,0,0,0,8'h00, 0,0,8'h00,0);

    foreach (vq[n]) begin
      cycle(vq[n].rst, vq[n].si, vq[n].so, vq[n].fl, vq[n].iv, vq[n].id);
      chk($sformatf("vec%0d_stall_req", n), vq[n].t,
          32'(a_sr[vq[n].t]), 32'(vq[n].sr));
      chk($sformatf("vec%0d_out_valid", n), vq[n].t,
          32'(ov[vq[n].t]), 32'(vq[n].ov));
      chk($sformatf("vec%0d_out_data", n), vq[n].t,
          32'(od[vq[n].t]), 32'(vq[n].od));
      chk($sformatf("vec%0d_occupancy", n), vq[n].t,
          32'(occ[vq[n].t]), 32'(vq[n].oc));
    end

    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(63) != 0,
            $urandom_range(3) == 0,
            $urandom_range(2) == 0,
            $urandom_range(19) == 0,
            $urandom_range(3) != 0,
            8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
